// File: rtl/window_generator.sv
// window_generator
// Converts a raster pixel stream into 3x3 neighbourhood windows for the
// downstream convolution pipeline. Two line buffers hold the previous two
// lines; a 3x3 register window shifts left on every accepted pixel. Only
// fully populated windows (row >= 2, col >= 2) are flagged valid.

module window_generator #(
    parameter int C_SIGNAL_WIDTH     = 12,
    parameter int C_KERNEL_DIMENSION = 3,
    parameter int C_IMG_WIDTH        = 640,
    parameter int C_IMG_HEIGHT       = 480
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_SIGNAL_WIDTH-1:0]              pixel_in,
    input  logic                                   pixel_valid,
    input  logic                                   frame_start,
    output logic [0:C_KERNEL_DIMENSION-1][0:C_KERNEL_DIMENSION-1][C_SIGNAL_WIDTH-1:0] window_out,
    output logic                                   window_valid,
    output logic                                   window_last
);

    localparam int K  = C_KERNEL_DIMENSION;
    localparam int SW = C_SIGNAL_WIDTH;
    localparam int CW = (C_IMG_WIDTH  > 1) ? $clog2(C_IMG_WIDTH)  : 1;
    localparam int RW = (C_IMG_HEIGHT > 1) ? $clog2(C_IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(C_IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(C_IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    // The new-column wiring below assumes exactly three window rows.
    generate
        if (C_KERNEL_DIMENSION != 3) begin : gen_bad_kernel
            $error("window_generator supports only C_KERNEL_DIMENSION = 3");
        end
        if (C_IMG_WIDTH < 3 || C_IMG_HEIGHT < 3) begin : gen_bad_image
            $error("window_generator needs an image of at least 3x3 pixels");
        end
    endgenerate

    logic [CW-1:0] colCount_q, colCount_d;
    logic [RW-1:0] rowCount_q, rowCount_d;
    logic [CW-1:0] colCur;
    logic [RW-1:0] rowCur;

    logic [SW-1:0] lineBuf0 [0:C_IMG_WIDTH-1];
    logic [SW-1:0] lineBuf1 [0:C_IMG_WIDTH-1];
    logic [SW-1:0] lb0Rd, lb1Rd;

    logic [0:K-1][0:K-1][SW-1:0] window_q;
    logic                        windowValid_q;
    logic                        windowLast_q;

    // Position of the incoming pixel: frame_start overrides the counters to (0,0).
    always_comb begin
        colCur = colCount_q;
        rowCur = rowCount_q;
        if (frame_start) begin
            colCur = '0;
            rowCur = '0;
        end
    end

    // Raster counter advance; a frame_start pixel leaves the counters at (0,1).
    always_comb begin
        colCount_d = colCount_q;
        rowCount_d = rowCount_q;
        if (pixel_valid) begin
            if (frame_start) begin
                colCount_d = COL_ONE;
                rowCount_d = '0;
            end else if (colCount_q == COL_LAST) begin
                colCount_d = '0;
                rowCount_d = (rowCount_q == ROW_LAST) ? '0 : rowCount_q + RW'(1);
            end else begin
                colCount_d = colCount_q + CW'(1);
            end
        end
    end

    // Line buffer read at the current column, taken before this cycle's write.
    always_comb begin
        lb0Rd = lineBuf0[colCur];
        lb1Rd = lineBuf1[colCur];
    end

    // Line buffers are plain RAM with no reset; valid gating hides stale data.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lineBuf1[colCur] <= lb0Rd;
            lineBuf0[colCur] <= pixel_in;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colCount_q <= '0;
            rowCount_q <= '0;
        end else begin
            colCount_q <= colCount_d;
            rowCount_q <= rowCount_d;
        end
    end

    // Window shift: each row moves left, the new right column comes from the line buffers and pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window_q <= '0;
        end else if (pixel_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    window_q[r][c] <= window_q[r][c+1];
                end
            end
            window_q[0][K-1] <= lb1Rd;
            window_q[1][K-1] <= lb0Rd;
            window_q[2][K-1] <= pixel_in;
        end
    end

    // Valid and last flags, registered alongside the window so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            windowValid_q <= 1'b0;
            windowLast_q  <= 1'b0;
        end else begin
            windowValid_q <= pixel_valid && (rowCur >= ROW_TWO) && (colCur >= COL_TWO);
            windowLast_q  <= pixel_valid && (rowCur == ROW_LAST) && (colCur == COL_LAST);
        end
    end

    assign window_out   = window_q;
    assign window_valid = windowValid_q;
    assign window_last  = windowLast_q;

endmodule

// File: tb/tb_window_generator.sv
// tb_window_generator
// Drives a 5x4 image through window_generator and checks every cycle against
// a frame-image model: each accepted pixel is written into a 2D array at its
// raster position, and the expected window is read straight out of that array.

module tb_window_generator;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int SW = 12;

    logic                           clk;
    logic                           rst;
    logic [SW-1:0]                  pixel_in;
    logic                           pixel_valid;
    logic                           frame_start;
    logic [0:2][0:2][SW-1:0]        window_out;
    logic                           window_valid;
    logic                           window_last;

    int total;
    int bad;

    int            p;
    logic [SW-1:0] img [0:H-1][0:W-1];

    logic [SW-1:0] obsCentres [$];
    int            lastCnt;
    logic [SW-1:0] lastCorner;
    logic [0:2][0:2][SW-1:0] firstWin;
    int            allWindows;
    int            allLasts;

    window_generator #(
        .C_SIGNAL_WIDTH     (SW),
        .C_KERNEL_DIMENSION (3),
        .C_IMG_WIDTH        (W),
        .C_IMG_HEIGHT       (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_in     (pixel_in),
        .pixel_valid  (pixel_valid),
        .frame_start  (frame_start),
        .window_out   (window_out),
        .window_valid (window_valid),
        .window_last  (window_last)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearFrameLog();
        obsCentres.delete();
        lastCnt    = 0;
        lastCorner = '0;
        firstWin   = '0;
    endtask

    // One clock of stimulus; the model position is pure arithmetic on a pixel index.
    task automatic applyStimulus(input logic [SW-1:0] value, input logic valid, input logic fs);
        int r;
        int c;
        logic expV;
        logic expL;
        logic [0:2][0:2][SW-1:0] expW;
        pixel_in    = value;
        pixel_valid = valid;
        frame_start = fs;
        expV = 1'b0;
        expL = 1'b0;
        expW = '0;
        if (valid) begin
            if (fs) p = 0;
            r = p / W;
            c = p % W;
            img[r][c] = value;
            if (r >= 2 && c >= 2) begin
                expV = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        expW[i][j] = img[r-2+i][c-2+j];
            end
            expL = (r == H - 1) && (c == W - 1);
            p = (p + 1) % (W * H);
        end
        @(posedge clk);
        #1;
        checkOutput("window_valid", 128'(window_valid), 128'(expV));
        checkOutput("window_last", 128'(window_last), 128'(expL));
        if (expV) checkOutput("window_out", 128'(window_out), 128'(expW));
        if (window_valid === 1'b1) begin
            if (obsCentres.size() == 0) firstWin = window_out;
            obsCentres.push_back(window_out[1][1]);
            allWindows++;
            if (window_last === 1'b1) begin
                lastCnt++;
                allLasts++;
                lastCorner = window_out[2][2];
            end
        end
    endtask

    // A whole frame of 16*r+c pixels, with random stall cycles at gapPct percent.
    task automatic sendFrame(input logic useFs, input int gapPct);
        clearFrameLog();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while (int'($urandom_range(99)) < gapPct)
                    applyStimulus(SW'($urandom), 1'b0, 1'($urandom_range(1)));
                applyStimulus(SW'(16 * r + c), 1'b1, useFs && r == 0 && c == 0);
            end
        end
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    // Frame-level checks against the fixed numbers of the 5x4 test image.
    task automatic checkFrame(input string tag);
        int centres [6] = '{17, 18, 19, 33, 34, 35};
        logic [0:2][0:2][SW-1:0] firstExp;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                firstExp[i][j] = SW'(16 * i + j);
        checkOutput({tag, "_count"}, 128'(obsCentres.size()), 128'(6));
        for (int i = 0; i < 6 && i < obsCentres.size(); i++)
            checkOutput($sformatf("%s_centre%0d", tag, i), 128'(obsCentres[i]), 128'(centres[i]));
        checkOutput({tag, "_first"}, 128'(firstWin), 128'(firstExp));
        checkOutput({tag, "_lastcnt"}, 128'(lastCnt), 128'(1));
        checkOutput({tag, "_lastcorner"}, 128'(lastCorner), 128'(52));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        p           = 0;
        allWindows  = 0;
        allLasts    = 0;
        rst         = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        clearFrameLog();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 128'(window_valid), 128'(0));
        checkOutput("reset_last", 128'(window_last), 128'(0));
        checkOutput("reset_window", 128'(window_out), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single frame, continuous");
        sendFrame(1'b1, 0);
        checkFrame("t2");

        $display("[TB] single frame, random stalls");
        sendFrame(1'b1, 30);
        checkFrame("t3");

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 9; k++)
            applyStimulus(SW'(16 * (k / W) + k % W), 1'b1, k == 0);
        rst = 1'b0;
        #2;
        checkOutput("midreset_valid", 128'(window_valid), 128'(0));
        checkOutput("midreset_window", 128'(window_out), 128'(0));
        @(posedge clk);
        #1;
        checkOutput("midreset_valid_hold", 128'(window_valid), 128'(0));
        checkOutput("midreset_last_hold", 128'(window_last), 128'(0));
        rst = 1'b1;
        p   = 0;
        sendFrame(1'b0, 0);
        checkFrame("t4");

        $display("[TB] frame_start resync mid-frame");
        for (int k = 0; k < 7; k++)
            applyStimulus(SW'(16 * (k / W) + k % W), 1'b1, k == 0);
        sendFrame(1'b1, 0);
        checkFrame("t5");

        $display("[TB] back-to-back frames");
        allWindows = 0;
        allLasts   = 0;
        sendFrame(1'b1, 0);
        checkFrame("t6a");
        sendFrame(1'b1, 0);
        checkFrame("t6b");
        checkOutput("t6_windows", 128'(allWindows), 128'(12));
        checkOutput("t6_lasts", 128'(allLasts), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
